// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: command encoding and pointer wrap helper shared by the SPI RAM blocks.
package spi_ram_pkg;
    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    function automatic int unsigned next_ptr(int unsigned ptr, int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/spi_ram_burst_if.sv
// spi_ram_burst_if: command word stream in, read data and status out.
interface spi_ram_burst_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH+1:0] din;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] dout;
    logic                  tx_valid;
    logic                  addr_err;
    modport master (output din, rx_valid, input dout, tx_valid, addr_err);
    modport slave  (input din, rx_valid, output dout, tx_valid, addr_err);
endinterface

// File: rtl/ram_ptr.sv
// ram_ptr: loadable address pointer with range check and optional wrapping post-increment.
module ram_ptr
    import spi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int AUTO_INC   = 1,
    parameter int VAL_WIDTH  = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [VAL_WIDTH-1:0]  load_val,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  range_err
);
    logic in_range;
    // compare in 32 bits so DEPTH == 2**ADDR_WIDTH does not truncate to zero
    assign in_range  = 32'(load_val) < 32'(DEPTH);
    assign range_err = load && !in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else if (load && in_range) ptr <= load_val[ADDR_WIDTH-1:0];
        else if (step && AUTO_INC != 0) ptr <= ADDR_WIDTH'(next_ptr(32'(ptr), 32'(DEPTH)));
    end
endmodule

// File: rtl/spi_ram_burst.sv
// spi_ram_burst: SPI-command-driven single-port RAM with independent write/read pointers
// and optional wrapping burst mode.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int AUTO_INC   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_ram_burst_if.slave bus
);
    cmd_e                  cmd;
    logic [DATA_WIDTH-1:0] payload;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  wr_err, rd_err;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign cmd     = cmd_e'(bus.din[DATA_WIDTH+1:DATA_WIDTH]);
    assign payload = bus.din[DATA_WIDTH-1:0];

    ram_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .AUTO_INC(AUTO_INC), .VAL_WIDTH(DATA_WIDTH)) u_wr (
        .clk(clk), .rst_n(rst_n),
        .load(bus.rx_valid && cmd == CMD_WR_ADDR), .load_val(payload),
        .step(bus.rx_valid && cmd == CMD_WR_DATA),
        .ptr(wr_ptr), .range_err(wr_err)
    );

    ram_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .AUTO_INC(AUTO_INC), .VAL_WIDTH(DATA_WIDTH)) u_rd (
        .clk(clk), .rst_n(rst_n),
        .load(bus.rx_valid && cmd == CMD_RD_ADDR), .load_val(payload),
        .step(bus.rx_valid && cmd == CMD_RD_DATA),
        .ptr(rd_ptr), .range_err(rd_err)
    );

    // memory is deliberately left out of reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (bus.rx_valid && cmd == CMD_WR_DATA) mem[wr_ptr] <= payload;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout     <= '0;
            bus.tx_valid <= 1'b0;
            bus.addr_err <= 1'b0;
        end else begin
            bus.addr_err <= wr_err || rd_err;
            if (bus.rx_valid) begin
                bus.tx_valid <= cmd == CMD_RD_DATA;
                if (cmd == CMD_RD_DATA) bus.dout <= mem[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_spi_ram_burst.sv
// tb_spi_ram_burst: three parameterisations (default, DEPTH=200, DEPTH=13 static pointer)
// checked against a behavioural model of the command set.
module tb_spi_ram_burst;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din_d [3];
    logic       rxv   [3];
    logic [7:0] dout_o[3];
    logic       tx_o  [3];
    logic       err_o [3];

    int checks = 0;
    int errors = 0;

    int         depth_a[3] = '{256, 200, 13};
    int         inc_a  [3] = '{1, 1, 0};
    logic [7:0] m_mem  [3][256];
    bit         m_known[3][256];
    int         m_wr[3], m_rd[3];
    logic [7:0] m_dout[3];
    bit         m_dk[3], m_tx[3], m_err[3];

    always #5 clk = ~clk;

    spi_ram_burst_if #(.DATA_WIDTH(8)) if0 ();
    spi_ram_burst_if #(.DATA_WIDTH(8)) if1 ();
    spi_ram_burst_if #(.DATA_WIDTH(8)) if2 ();

    assign if0.din = din_d[0]; assign if0.rx_valid = rxv[0];
    assign if1.din = din_d[1]; assign if1.rx_valid = rxv[1];
    assign if2.din = din_d[2]; assign if2.rx_valid = rxv[2];
    assign dout_o[0] = if0.dout; assign tx_o[0] = if0.tx_valid; assign err_o[0] = if0.addr_err;
    assign dout_o[1] = if1.dout; assign tx_o[1] = if1.tx_valid; assign err_o[1] = if1.addr_err;
    assign dout_o[2] = if2.dout; assign tx_o[2] = if2.tx_valid; assign err_o[2] = if2.addr_err;

    spi_ram_burst u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    spi_ram_burst #(.DEPTH(200)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    spi_ram_burst #(.ADDR_WIDTH(4), .DEPTH(13), .AUTO_INC(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    task automatic check_all(string tag);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_o[i] !== m_tx[i]) begin
                errors++;
                $display("FAIL %s dut%0d tx_valid: got %b expected %b", tag, i, tx_o[i], m_tx[i]);
            end
            checks++;
            if (err_o[i] !== m_err[i]) begin
                errors++;
                $display("FAIL %s dut%0d addr_err: got %b expected %b", tag, i, err_o[i], m_err[i]);
            end
            if (m_dk[i]) begin
                checks++;
                if (dout_o[i] !== m_dout[i]) begin
                    errors++;
                    $display("FAIL %s dut%0d dout: got %h expected %h", tag, i, dout_o[i], m_dout[i]);
                end
            end
        end
    endtask

    // one clock cycle: dut d sees the command (if v), others idle
    task automatic step(int d, bit v, logic [1:0] c, logic [7:0] p);
        for (int i = 0; i < 3; i++) begin
            din_d[i] = (i == d) ? {c, p} : 10'd0;
            rxv[i]   = (i == d) && v;
            m_err[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        if (v) begin
            m_tx[d] = (c == 2'b11);
            case (c)
                2'b00: if (int'(p) < depth_a[d]) m_wr[d] = int'(p); else m_err[d] = 1'b1;
                2'b01: begin
                    m_mem[d][m_wr[d]]   = p;
                    m_known[d][m_wr[d]] = 1'b1;
                    if (inc_a[d] != 0) m_wr[d] = (m_wr[d] + 1) % depth_a[d];
                end
                2'b10: if (int'(p) < depth_a[d]) m_rd[d] = int'(p); else m_err[d] = 1'b1;
                default: begin
                    m_dout[d] = m_mem[d][m_rd[d]];
                    m_dk[d]   = m_known[d][m_rd[d]];
                    if (inc_a[d] != 0) m_rd[d] = (m_rd[d] + 1) % depth_a[d];
                end
            endcase
        end
        check_all("step");
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) rxv[i] = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            m_wr[i] = 0; m_rd[i] = 0; m_dout[i] = 8'h00; m_dk[i] = 1'b1; m_tx[i] = 1'b0; m_err[i] = 1'b0;
        end
        check_all("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_burst_default();
        step(0, 1, 2'b00, 8'h10);
        step(0, 1, 2'b01, 8'hA1);
        step(0, 1, 2'b01, 8'hA2);
        step(0, 1, 2'b01, 8'hA3);
        step(0, 1, 2'b10, 8'h10);
        step(0, 1, 2'b11, 8'h00);
        checks++; if (dout_o[0] !== 8'hA1 || tx_o[0] !== 1'b1) begin errors++; $display("FAIL burst0 dout=%h tx=%b expected a1/1", dout_o[0], tx_o[0]); end
        step(0, 1, 2'b11, 8'h00);
        checks++; if (dout_o[0] !== 8'hA2 || tx_o[0] !== 1'b1) begin errors++; $display("FAIL burst1 dout=%h tx=%b expected a2/1", dout_o[0], tx_o[0]); end
        step(0, 1, 2'b11, 8'h00);
        checks++; if (dout_o[0] !== 8'hA3 || tx_o[0] !== 1'b1) begin errors++; $display("FAIL burst2 dout=%h tx=%b expected a3/1", dout_o[0], tx_o[0]); end
        step(0, 1, 2'b00, 8'h20);
        checks++; if (dout_o[0] !== 8'hA3 || tx_o[0] !== 1'b0) begin errors++; $display("FAIL burst_drop dout=%h tx=%b expected a3/0", dout_o[0], tx_o[0]); end
    endtask

    task automatic test_idle();
        step(0, 1, 2'b10, 8'h10);
        step(0, 1, 2'b11, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 2'b11, 8'h00);
            checks++; if (dout_o[0] !== 8'hA1 || tx_o[0] !== 1'b1) begin errors++; $display("FAIL idle dout=%h tx=%b expected a1/1", dout_o[0], tx_o[0]); end
        end
    endtask

    task automatic test_wrap();
        step(1, 1, 2'b00, 8'd199);
        step(1, 1, 2'b01, 8'h55);
        step(1, 1, 2'b01, 8'h66);
        step(1, 1, 2'b10, 8'd199);
        step(1, 1, 2'b11, 8'h00);
        checks++; if (dout_o[1] !== 8'h55) begin errors++; $display("FAIL wrap199 dout=%h expected 55", dout_o[1]); end
        step(1, 1, 2'b11, 8'h00);
        checks++; if (dout_o[1] !== 8'h66) begin errors++; $display("FAIL wrap0 dout=%h expected 66", dout_o[1]); end
    endtask

    task automatic test_addr_err();
        step(1, 1, 2'b00, 8'd200);
        checks++; if (err_o[1] !== 1'b1) begin errors++; $display("FAIL addr_err_hi got %b expected 1", err_o[1]); end
        step(1, 1, 2'b01, 8'h77);
        checks++; if (err_o[1] !== 1'b0) begin errors++; $display("FAIL addr_err_lo got %b expected 0", err_o[1]); end
        step(1, 1, 2'b10, 8'd1);
        step(1, 1, 2'b11, 8'h00);
        checks++; if (dout_o[1] !== 8'h77) begin errors++; $display("FAIL err_keep_ptr dout=%h expected 77", dout_o[1]); end
        step(2, 1, 2'b10, 8'h15);
        checks++; if (err_o[2] !== 1'b1) begin errors++; $display("FAIL upper_bits_err got %b expected 1", err_o[2]); end
    endtask

    task automatic test_static();
        step(2, 1, 2'b00, 8'd5);
        step(2, 1, 2'b01, 8'h11);
        step(2, 1, 2'b01, 8'h22);
        step(2, 1, 2'b10, 8'd5);
        for (int k = 0; k < 2; k++) begin
            step(2, 1, 2'b11, 8'h00);
            checks++; if (dout_o[2] !== 8'h22) begin errors++; $display("FAIL static dout=%h expected 22", dout_o[2]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        step(0, 1, 2'b00, 8'h00);
        step(0, 1, 2'b01, 8'h3C);
        step(0, 1, 2'b00, 8'h40);
        step(0, 1, 2'b01, 8'h01);
        step(0, 1, 2'b01, 8'h02);
        do_reset();
        step(0, 1, 2'b11, 8'h00);
        checks++; if (dout_o[0] !== 8'h3C) begin errors++; $display("FAIL mid_reset_rd dout=%h expected 3c", dout_o[0]); end
        step(0, 1, 2'b01, 8'h99);
        step(0, 1, 2'b10, 8'h00);
        step(0, 1, 2'b11, 8'h00);
        checks++; if (dout_o[0] !== 8'h99) begin errors++; $display("FAIL mid_reset_wr dout=%h expected 99", dout_o[0]); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            int         d;
            logic [1:0] c;
            logic [7:0] p;
            d = int'($urandom_range(0, 2));
            c = 2'($urandom);
            p = (c[0] == 1'b0 && $urandom_range(0, 7) != 0) ? 8'($urandom_range(0, depth_a[d] - 1)) : 8'($urandom);
            step(d, $urandom_range(0, 3) != 0, c, p);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            din_d[i] = '0;
            rxv[i] = 1'b0;
            for (int a = 0; a < 256; a++) m_known[i][a] = 1'b0;
        end
        #12;
        test_reset();
        test_burst_default();
        test_idle();
        test_wrap();
        test_addr_err();
        test_static();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_ram_burst.md
# spi_ram_burst

Parametrised single-port RAM driven by the SPI slave's command word stream, succeeding the fixed 256x8 SPI RAM. It decodes a 2-bit command on each `rx_valid` beat and keeps independent write and read address pointers. It adds optional auto-increment burst mode with wrap at `DEPTH-1`, non-power-of-two depth, and an out-of-range address error pulse. It sits between the SPI slave and the wrapper's MISO return path.

## Interface
- `DATA_WIDTH`, 8: memory word width; payload width of `din`.
- `ADDR_WIDTH`, 8: pointer width; must satisfy `ADDR_WIDTH <= DATA_WIDTH` and `2**ADDR_WIDTH >= DEPTH`.
- `DEPTH`, 256: number of words; any value in `2..2**ADDR_WIDTH`.
- `AUTO_INC`, 1: 1 = pointer post-increments after each data command; 0 = pointer static.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `din`  in  DATA_WIDTH+2  `din[DATA_WIDTH+1:DATA_WIDTH]` = command, `din[DATA_WIDTH-1:0]` = payload.
- `rx_valid`  in  1  `din` valid this cycle; one command per cycle.
- `dout`  out  DATA_WIDTH  read data.
- `tx_valid`  out  1  `dout` holds data from a read-data command.
- `addr_err`  out  1  one-cycle pulse: rejected address.

## Operation
- Commands are decoded only when `rx_valid=1`. When `rx_valid=0`, no state changes and all outputs hold.
- `00` WR_ADDR: if `payload[ADDR_WIDTH-1:0] < DEPTH` and the upper payload bits are 0, `wr_ptr <= payload`. Otherwise `wr_ptr` is unchanged and `addr_err` pulses.
- `01` WR_DATA: `mem[wr_ptr] <= payload`. If `AUTO_INC`, `wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1`.
- `10` RD_ADDR: same validity rule as WR_ADDR, applied to `rd_ptr`.
- `11` RD_DATA: `dout <= mem[rd_ptr]` and `tx_valid <= 1`. If `AUTO_INC`, `rd_ptr` increments with the same wrap rule.
- Any valid command other than `11` forces `tx_valid <= 0`. `dout` keeps its last value.
- Write and read pointers are fully independent. A WR_DATA followed by RD_DATA at the same address returns the new data.
- Reset: `dout=0`, `tx_valid=0`, `addr_err=0`, `wr_ptr=0`, `rd_ptr=0`. Memory contents are not cleared; they are undefined after power-up and preserved across `rst_n`.
- Reset asserted mid-burst: pointers return to 0. A burst resumed after reset needs a new address command to target the old location.

## Timing
- Read latency: 1 cycle. `tx_valid` and `dout` update on the edge that samples RD_DATA.
- Back-to-back RD_DATA with `AUTO_INC=1`: consecutive words appear on consecutive cycles, and `tx_valid` stays high.
- `addr_err` is high exactly one cycle, on the edge after the offending command.
- Write takes effect on the sampling edge. A read of that address on the next edge sees it.
- Asynchronous reset clears registered outputs immediately. The first command is accepted on the first rising edge with `rst_n=1`.

## Structure
- Package `spi_ram_pkg`:
  - enum `cmd_e`: `CMD_WR_ADDR=2'b00`, `CMD_WR_DATA=2'b01`, `CMD_RD_ADDR=2'b10`, `CMD_RD_DATA=2'b11`.
  - Helper function `next_ptr(ptr, depth)` implementing the wrap rule.
- Sub-module `ram_ptr`: one instance each for write and read.
  - Parameters `ADDR_WIDTH`, `DEPTH`, `AUTO_INC`.
  - Inputs `load`, `load_val`, `step`; outputs `ptr`, `range_err`.
- Memory is an inferred array in the top module.

## Test plan
1. Reset with `rx_valid=0` -> `dout=0`, `tx_valid=0`, `addr_err=0`. `rst_n` low mid-burst clears pointers, and the next RD_DATA reads address 0.
2. Defaults (`AUTO_INC=1`): WR_ADDR 0x10, WR_DATA 0xA1, 0xA2, 0xA3, then RD_ADDR 0x10, RD_DATA x3 -> `dout` = 0xA1, 0xA2, 0xA3 on three consecutive cycles with `tx_valid=1`. The next WR_ADDR drops `tx_valid` to 0 while `dout` stays 0xA3.
3. `DEPTH=200`, `ADDR_WIDTH=8`:
   - WR_ADDR 199, WR_DATA 0x55, WR_DATA 0x66 -> `mem[199]=0x55`, `mem[0]=0x66`.
   - RD_ADDR 199, RD_DATA x2 -> 0x55 then 0x66.
4. `DEPTH=200`: WR_ADDR 200 -> `addr_err` high one cycle, `wr_ptr` unchanged. A following WR_DATA 0x77 lands at the previous pointer.
5. `AUTO_INC=0`: WR_ADDR 5, WR_DATA 0x11, WR_DATA 0x22, RD_ADDR 5, RD_DATA x2 -> `dout` = 0x22 both cycles.
6. Data path: RD_DATA with `rx_valid=0` -> `tx_valid` and `dout` stable.
